// File: rtl/uart_cfg_ctrl.sv
// uart_cfg_ctrl
//   Frame-level controller behind uart_rx. Enables the receiver, parses
//   configuration frames  SOF, ADDR, LEN, DATA[0..LEN-1], CHK  with
//   CHK = ADDR ^ LEN ^ all DATA bytes, buffers the payload and, only for a
//   frame whose checksum matches, issues one register write per cycle.
//
// Ports
//   i_Clock      system clock
//   i_Rst_n      asynchronous active-low reset
//   i_Enable     controller enable; low forces IDLE on the next edge
//   i_Rx_DV      byte-valid pulse from uart_rx
//   i_Rx_Byte    received byte (valid with i_Rx_DV)
//   o_Rx_Enable  enable for uart_rx (high in every state except IDLE)
//   o_Busy       frame in progress (ADDR..COMMIT)
//   o_Cfg_Wr     register write strobe
//   o_Cfg_Addr   write address (base + i, wraps at 2^ADDR_W)
//   o_Cfg_Data   write data
//   o_Frame_Ok   1-cycle pulse after the last write of a good frame
//   o_Frame_Err  1-cycle pulse on a discarded frame
//   o_Err_Code   1=bad LEN, 2=bad CHK, 3=timeout; updated on each Ok/Err pulse
module uart_cfg_ctrl #(
  parameter logic [7:0]  SOF_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT_CLKS = 57288
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Enable,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Rx_Enable,
  output logic              o_Busy,
  output logic              o_Cfg_Wr,
  output logic [ADDR_W-1:0] o_Cfg_Addr,
  output logic [7:0]        o_Cfg_Data,
  output logic              o_Frame_Ok,
  output logic              o_Frame_Err,
  output logic [1:0]        o_Err_Code
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]    MAX_LEN9 = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_ADDR, S_LEN, S_DATA, S_CHK, S_COMMIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LW-1:0]     len;
  logic [LW-1:0]     idx;    // payload index in DATA, write index in COMMIT
  logic [7:0]        chk;
  logic [TW-1:0]     tcnt;
  logic [7:0]        data_buf [2**IW];

  // Payload storage carries no reset; contents only matter once a frame is
  // fully received.
  always_ff @(posedge i_Clock) begin
    if (i_Enable && state == S_DATA && i_Rx_DV)
      data_buf[idx[IW-1:0]] <= i_Rx_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= S_IDLE;
      base        <= '0;
      len         <= '0;
      idx         <= '0;
      chk         <= '0;
      tcnt        <= '0;
      o_Rx_Enable <= 1'b0;
      o_Busy      <= 1'b0;
      o_Cfg_Wr    <= 1'b0;
      o_Cfg_Addr  <= '0;
      o_Cfg_Data  <= '0;
      o_Frame_Ok  <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Err_Code  <= '0;
    end else begin
      o_Cfg_Wr    <= 1'b0;
      o_Frame_Ok  <= 1'b0;
      o_Frame_Err <= 1'b0;

      if (!i_Enable) begin
        state       <= S_IDLE;
        o_Rx_Enable <= 1'b0;
        o_Busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state       <= S_HUNT;
            o_Rx_Enable <= 1'b1;
          end

          S_HUNT: begin
            if (i_Rx_DV && i_Rx_Byte == SOF_BYTE) begin
              state  <= S_ADDR;
              o_Busy <= 1'b1;
              tcnt   <= '0;
            end
          end

          S_ADDR, S_LEN, S_DATA, S_CHK: begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (i_Rx_DV) begin
              tcnt <= '0;
              case (state)
                S_ADDR: begin
                  base  <= ADDR_W'(i_Rx_Byte);
                  chk   <= i_Rx_Byte;
                  state <= S_LEN;
                end
                S_LEN: begin
                  if (i_Rx_Byte == 8'd0 || {1'b0, i_Rx_Byte} > MAX_LEN9) begin
                    state       <= S_HUNT;
                    o_Busy      <= 1'b0;
                    o_Frame_Err <= 1'b1;
                    o_Err_Code  <= 2'd1;
                  end else begin
                    len   <= LW'(i_Rx_Byte);
                    chk   <= chk ^ i_Rx_Byte;
                    idx   <= '0;
                    state <= S_DATA;
                  end
                end
                S_DATA: begin
                  chk <= chk ^ i_Rx_Byte;
                  idx <= idx + LW'(1);
                  if (idx == len - LW'(1))
                    state <= S_CHK;
                end
                default: begin  // S_CHK
                  if (i_Rx_Byte == chk) begin
                    // First write leaves on this edge; COMMIT issues the rest.
                    state      <= S_COMMIT;
                    o_Cfg_Wr   <= 1'b1;
                    o_Cfg_Addr <= base;
                    o_Cfg_Data <= data_buf[0];
                    idx        <= LW'(1);
                  end else begin
                    state       <= S_HUNT;
                    o_Busy      <= 1'b0;
                    o_Frame_Err <= 1'b1;
                    o_Err_Code  <= 2'd2;
                  end
                end
              endcase
            end else if (tcnt == T_LAST) begin
              state       <= S_HUNT;
              o_Busy      <= 1'b0;
              o_Frame_Err <= 1'b1;
              o_Err_Code  <= 2'd3;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end

          S_COMMIT: begin
            // Incoming bytes are ignored until the burst completes.
            if (idx != len) begin
              o_Cfg_Wr   <= 1'b1;
              o_Cfg_Addr <= base + ADDR_W'(idx);
              o_Cfg_Data <= data_buf[idx[IW-1:0]];
              idx        <= idx + LW'(1);
            end else begin
              state      <= S_HUNT;
              o_Busy     <= 1'b0;
              o_Frame_Ok <= 1'b1;
              o_Err_Code <= 2'd0;
            end
          end

          default: begin
            state       <= S_IDLE;
            o_Rx_Enable <= 1'b0;
            o_Busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
